// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC, addresses the
// instruction memory and registers the returned word into the IF/ID pipeline register.
module riscv_fetch_stage #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   RESET_PC    = 32'h00000000,
  parameter int                IMEM_ADDR_W = 10,
  parameter logic [31:0]       NOP_INSTR   = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        pc_out,
  output logic [XLEN-1:0]        if_id_pc,
  output logic [XLEN-1:0]        if_id_pc_plus4,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
  output logic                   misalign_err
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] pc_plus4;

  // Wraps modulo 2^XLEN; addresses beyond the memory alias via truncation.
  assign pc_plus4  = pc_q + PC_STEP;
  assign imem_addr = pc_q[IMEM_ADDR_W+1:2];

  always_comb begin
    pc_d             = pc_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;
    misalign_err_d   = misalign_err_q;

    if (redirect) begin
      // Bubble keeps the old PC fields; only instr/valid change.
      pc_d          = {redirect_pc[XLEN-1:2], 2'b00};
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err_d = 1'b1;
      end
    end else if (stall) begin
      if (flush) begin
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
    end else if (flush) begin
      pc_d          = pc_plus4;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else begin
      pc_d             = pc_plus4;
      if_id_pc_d       = pc_q;
      if_id_pc_plus4_d = pc_plus4;
      if_id_instr_d    = imem_rdata;
      if_id_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      misalign_err_q   <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      misalign_err_q   <= misalign_err_d;
    end
  end

  assign pc_out         = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;
  assign misalign_err   = misalign_err_q;

endmodule

// File: doc/riscv_fetch_stage.md
Name: riscv_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipelined RV32I core.
- Sits directly upstream of the decode stage.
- Owns the program counter, drives the word address into the instruction memory (the memory loaded from the test hex file), and registers the returned instruction into the IF/ID pipeline register.
- Honours stall from the hazard unit and flush/redirect from the branch-resolution logic in EX.

Parameters:
- XLEN, 32, width of PC and address datapath.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_ADDR_W, 10, word-address width of the instruction memory (1024 words).
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  IMEM_ADDR_W  word address to instruction memory, equal to pc[IMEM_ADDR_W+1:2].
- imem_rdata  input  32  instruction word, combinational read of imem_addr.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  insert bubble into IF/ID.
- redirect  input  1  branch/jump taken in EX.
- redirect_pc  input  XLEN  target PC for redirect.
- pc_out  output  XLEN  current fetch PC.
- if_id_pc  output  XLEN  PC of the instruction in IF/ID.
- if_id_pc_plus4  output  XLEN  if_id_pc + 4, for JAL/JALR link.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:

Clock and reset:
- One clock, clk.
- Reset is asynchronous and active-high on rst.
- While rst=1, regardless of clk:
  - pc = RESET_PC
  - if_id_pc = 0, if_id_pc_plus4 = 0
  - if_id_instr = NOP_INSTR, if_id_valid = 0
  - misalign_err = 0
- Asserting rst mid-operation discards all state immediately, with no completion of the in-flight fetch.
- First edge after rst deasserts captures mem[RESET_PC>>2] into IF/ID with valid=1.

Datapath:
- imem_addr is combinational from pc.
- Fetch latency is one cycle: the instruction at pc appears on if_id_instr after the next rising edge.

Per rising edge, priority redirect > stall > normal:
- **redirect=1:**
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - IF/ID <= bubble (instr=NOP_INSTR, valid=0, pc fields hold previous value).
  - If redirect_pc[1:0] != 0, misalign_err <= 1, sticky until rst.
  - stall and flush are ignored this cycle.
- **stall=1, redirect=0:**
  - pc holds.
  - IF/ID holds all fields, unless flush=1, in which case IF/ID <= bubble and pc still holds.
- **flush=1, stall=0, redirect=0:**
  - IF/ID <= bubble.
  - pc <= pc+4, i.e. the fetched instruction is dropped.
- **normal:**
  - if_id_pc <= pc, if_id_pc_plus4 <= pc+4, if_id_instr <= imem_rdata, if_id_valid <= 1.
  - pc <= pc+4.

Arithmetic and boundaries:
- pc+4 is modulo 2^XLEN: pc=32'hFFFFFFFC wraps to 0.
- imem_addr truncates, so a PC beyond the memory size aliases into memory; no error is raised.
- Stall held for N cycles: IF/ID content is bit-identical for all N cycles.
- On stall release, fetch resumes from the held pc with no skipped or duplicated instruction.
- Redirect to the current pc is legal: a bubble is inserted and the same address is re-fetched.
- misalign_err is not cleared by flush or redirect; only rst clears it.

Test Plan:
1. **Reset and sequential fetch.** mem[0..3] = 00500093, 00A00113, 002081B3, 00000013; rst pulse, no stall/flush/redirect.
   - After edges 1..4, if_id_pc = 0, 4, 8, C and if_id_instr = the matching words.
   - if_id_valid=1 from edge 1; pc_out = 10 after edge 4.
2. **Stall hold.** At pc=8, assert stall for 3 cycles.
   - if_id_pc stays 4 with instr 00A00113 for 3 cycles; pc_out stays 8.
   - After release, next edge gives if_id_pc=8, instr 002081B3.
3. **Redirect with simultaneous stall.** At pc=C, redirect=1, redirect_pc=40, stall=1.
   - Next edge: pc_out=40, if_id_valid=0, if_id_instr=00000013.
   - Following edge: if_id_pc=40, valid=1.
4. **Misaligned redirect.** redirect_pc=32'h00000022.
   - pc_out=20, misalign_err=1.
   - misalign_err stays 1 through a later flush; clears only on rst.
5. **Flush alone.** At pc=10, flush=1 for one cycle.
   - Bubble in IF/ID; pc_out=14.
   - Next edge: if_id_pc=14, valid=1 (instruction at 10 is dropped).
6. **Async reset mid-run and PC wrap.**
   - rst asserted between edges at pc=24: outputs go to reset values before the next edge.
   - redirect_pc=FFFFFFFC followed by a normal edge: if_id_pc=FFFFFFFC, pc_out=00000000.
